// File: rtl/secuenciador_notas.sv
// Music-box playback sequencer: walks the note ROM address, holds each note for a
// fixed tone time plus a short silence, and drives the square-wave buzzer.
module secuenciador_notas #(
  parameter int unsigned N_NOTAS         = 25,
  parameter int unsigned CICLOS_NOTA     = 3000000,
  parameter int unsigned CICLOS_SILENCIO = 600000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        play,
  input  logic        stop,
  input  logic        loop,
  input  logic [15:0] ciclos_de_nota,
  output logic [4:0]  direccion_nota,
  output logic        buzzer,
  output logic        reproduciendo,
  output logic        fin
);

  localparam int unsigned CICLOS_MAX = (CICLOS_NOTA > CICLOS_SILENCIO) ? CICLOS_NOTA : CICLOS_SILENCIO;
  localparam int unsigned DW         = (CICLOS_MAX > 1) ? $clog2(CICLOS_MAX) : 1;
  localparam logic [DW-1:0] FIN_TONO     = DW'(CICLOS_NOTA - 1);
  localparam logic [DW-1:0] FIN_SILENCIO = DW'(CICLOS_SILENCIO - 1);
  localparam logic [4:0]    ULTIMA_NOTA  = 5'(N_NOTAS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TONO     = 2'd1,
    SILENCIO = 2'd2
  } estado_t;

  estado_t        estado;
  logic [DW-1:0]  duracion;
  logic [15:0]    h;
  logic [15:0]    h_fin_c;

  // Last half-period count; only meaningful when ciclos_de_nota is non-zero.
  assign h_fin_c = ciclos_de_nota - 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado         <= IDLE;
      direccion_nota <= 5'd0;
      buzzer         <= 1'b0;
      reproduciendo  <= 1'b0;
      fin            <= 1'b0;
      duracion       <= '0;
      h              <= 16'd0;
    end else begin
      fin <= 1'b0;
      case (estado)
        IDLE: begin
          if (play && !stop) begin
            estado         <= TONO;
            reproduciendo  <= 1'b1;
            direccion_nota <= 5'd0;
            duracion       <= '0;
            h              <= 16'd0;
            buzzer         <= 1'b0;
          end
        end

        TONO: begin
          if (stop) begin
            estado         <= IDLE;
            reproduciendo  <= 1'b0;
            direccion_nota <= 5'd0;
            duracion       <= '0;
            h              <= 16'd0;
            buzzer         <= 1'b0;
          end else if (duracion == FIN_TONO) begin
            // Tone time over: the buzzer is silenced regardless of its phase.
            estado   <= SILENCIO;
            duracion <= '0;
            h        <= 16'd0;
            buzzer   <= 1'b0;
          end else begin
            duracion <= duracion + DW'(1);
            if (ciclos_de_nota == 16'd0) begin
              h      <= 16'd0;
              buzzer <= 1'b0;
            end else if (h == h_fin_c) begin
              h      <= 16'd0;
              buzzer <= ~buzzer;
            end else begin
              h <= h + 16'd1;
            end
          end
        end

        SILENCIO: begin
          buzzer <= 1'b0;
          h      <= 16'd0;
          if (stop) begin
            estado         <= IDLE;
            reproduciendo  <= 1'b0;
            direccion_nota <= 5'd0;
            duracion       <= '0;
          end else if (duracion == FIN_SILENCIO) begin
            duracion <= '0;
            if (direccion_nota == ULTIMA_NOTA) begin
              // End of song: pulse fin and either wrap straight into note 0 or stop.
              fin            <= 1'b1;
              direccion_nota <= 5'd0;
              if (loop) begin
                estado <= TONO;
              end else begin
                estado        <= IDLE;
                reproduciendo <= 1'b0;
              end
            end else begin
              direccion_nota <= direccion_nota + 5'd1;
              estado         <= TONO;
            end
          end else begin
            duracion <= duracion + DW'(1);
          end
        end

        default: begin
          estado         <= IDLE;
          reproduciendo  <= 1'b0;
          direccion_nota <= 5'd0;
          duracion       <= '0;
          h              <= 16'd0;
          buzzer         <= 1'b0;
        end
      endcase
    end
  end

endmodule
